seven_seg_scanner: RTL

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seg_pkg.sv | 56 +++++
 rtl/seven_seg_scanner_if.sv | 27 ++
 rtl/bin2bcd_seq.sv | 85 ++++++++
 rtl/seven_seg_scanner.sv | 129 ++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scanner: segment patterns,
// converter state type and BCD sizing helper.
package seg_pkg;

   // Active-low cathode patterns, bit 6..0 = g..a
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      CONV_IDLE   = 2'd0,
      CONV_SHIFT  = 2'd1,
      CONV_COMMIT = 2'd2
   } conv_state_t;

   // Decimal digit count of the largest value representable in width bits.
   function automatic int bcd_digits_for(input int width);
      longint unsigned v;
      int              n;
      v = (64'd1 << width) - 64'd1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (v != 0) begin
            v = v / 64'd10;
            n = n + 1;
         end
      end
      return (n < 1) ? 1 : n;
   endfunction

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      case (nib)
         4'd0:    seg_decode = SEG_0;
         4'd1:    seg_decode = SEG_1;
         4'd2:    seg_decode = SEG_2;
         4'd3:    seg_decode = SEG_3;
         4'd4:    seg_decode = SEG_4;
         4'd5:    seg_decode = SEG_5;
         4'd6:    seg_decode = SEG_6;
         4'd7:    seg_decode = SEG_7;
         4'd8:    seg_decode = SEG_8;
         4'd9:    seg_decode = SEG_9;
         default: seg_decode = SEG_DASH;
      endcase
   endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Host-facing bundle of the scanner: value/load/display controls in,
// multiplexed segment drive and status out.
interface seven_seg_scanner_if #(
   parameter int NUM_DIGITS = 4,
   parameter int BIN_WIDTH  = 14
);
   logic [BIN_WIDTH-1:0]  bin;
   logic                  load;
   logic                  blank_lz;
   logic [NUM_DIGITS-1:0] dp;
   logic [3:0]            brightness;
   logic [6:0]            seg_cat;
   logic                  seg_dp;
   logic [NUM_DIGITS-1:0] seg_an;
   logic                  busy;
   logic                  ovf;

   modport master (
      output bin, load, blank_lz, dp, brightness,
      input  seg_cat, seg_dp, seg_an, busy, ovf
   );

   modport slave (
      input  bin, load, blank_lz, dp, brightness,
      output seg_cat, seg_dp, seg_an, busy, ovf
   );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one bit per cycle, then a single
// COMMIT cycle during which done is high and bcd is final.
module bin2bcd_seq
   import seg_pkg::*;
#(
   parameter int BIN_WIDTH  = 14,
   parameter int BCD_DIGITS = bcd_digits_for(BIN_WIDTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [BIN_WIDTH-1:0]    bin,
   output logic                    busy,
   output logic                    done,
   output logic [4*BCD_DIGITS-1:0] bcd
);
   localparam int CNT_W = $clog2(BIN_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BIN_WIDTH - 1);

   conv_state_t             state_q, state_d;
   logic [BIN_WIDTH-1:0]    shift_q, shift_d;
   logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d, bcd_adj;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   genvar gi;
   generate
      for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_adj
         assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                     bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CONV_IDLE;
         shift_q <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         CONV_IDLE:   if (start) state_d = CONV_SHIFT;
         CONV_SHIFT:  if (cnt_q == LAST_BIT) state_d = CONV_COMMIT;
         CONV_COMMIT: state_d = CONV_IDLE;
         default:     state_d = CONV_IDLE;
      endcase
   end

   // Datapath follows the state; start is only honoured in IDLE.
   always_comb begin
      shift_d = shift_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      case (state_q)
         CONV_IDLE: begin
            if (start) begin
               shift_d = bin;
               bcd_d   = '0;
               cnt_d   = '0;
            end
         end
         CONV_SHIFT: begin
            bcd_d   = {bcd_adj[4*BCD_DIGITS-2:0], shift_q[BIN_WIDTH-1]};
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      busy = (state_q != CONV_IDLE);
      done = (state_q == CONV_COMMIT);
      bcd  = bcd_q;
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment driver: holds the committed BCD value and scans
// it across the digits with leading-zero blanking, PWM dimming and overflow dashes.
module seven_seg_scanner
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int BIN_WIDTH   = 14,
   parameter int REFRESH_DIV = 100000
) (
   input  logic               clk,
   input  logic               rst,
   seven_seg_scanner_if.slave bus
);
   localparam int BCD_DIGITS = bcd_digits_for(BIN_WIDTH);
   localparam int EXT_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
   localparam int DIG_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PRE_W      = $clog2(REFRESH_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
   localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);

   logic                    conv_busy, conv_done, conv_ovf;
   logic [4*BCD_DIGITS-1:0] conv_bcd;
   logic [4*EXT_DIGITS-1:0] bcd_ext;

   logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
   logic                    ovf_q, ovf_d;
   logic [PRE_W-1:0]        presc_q, presc_d;
   logic [DIG_W-1:0]        digit_q, digit_d;
   logic [3:0]              pwm_cnt_q, pwm_cnt_d;
   logic [6:0]              seg_cat_q, seg_cat_d;
   logic                    seg_dp_q, seg_dp_d;
   logic [NUM_DIGITS-1:0]   seg_an_q, seg_an_d;

   logic                    wrap;
   logic [3:0]              cur_nib;
   logic [NUM_DIGITS-1:0]   lz_blank;

   bin2bcd_seq #(
      .BIN_WIDTH  (BIN_WIDTH),
      .BCD_DIGITS (BCD_DIGITS)
   ) u_conv (
      .clk   (clk),
      .rst   (rst),
      .start (bus.load),
      .bin   (bus.bin),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   assign bcd_ext = (4*EXT_DIGITS)'(conv_bcd);

   // Any nonzero digit beyond the display width means the value does not fit.
   generate
      if (EXT_DIGITS > NUM_DIGITS) begin : g_ovf
         assign conv_ovf = |bcd_ext[4*EXT_DIGITS-1:4*NUM_DIGITS];
      end else begin : g_no_ovf
         assign conv_ovf = 1'b0;
      end
   endgenerate

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
         if (gi == 0) begin : g_lsd
            assign lz_blank[gi] = 1'b0;
         end else begin : g_upper
            assign lz_blank[gi] = bus.blank_lz &&
                                  (disp_q[4*NUM_DIGITS-1:4*gi] == '0);
         end
      end
   endgenerate

   assign wrap    = (presc_q == PRE_LAST);
   assign cur_nib = disp_q[4*digit_q +: 4];

   always_comb begin
      disp_d    = conv_done ? bcd_ext[4*NUM_DIGITS-1:0] : disp_q;
      ovf_d     = conv_done ? conv_ovf : ovf_q;
      presc_d   = wrap ? '0 : presc_q + 1'b1;
      digit_d   = digit_q;
      if (wrap) digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
      pwm_cnt_d = pwm_cnt_q + 4'd1;
   end

   // Anodes stay dark on the wrap cycle so the old digit's pattern never
   // bleeds onto the next anode.
   always_comb begin
      seg_cat_d = seg_decode(cur_nib);
      seg_dp_d  = ~bus.dp[digit_q];
      seg_an_d  = '1;
      if (ovf_q) begin
         seg_cat_d = SEG_DASH;
         seg_dp_d  = 1'b1;
      end else if (lz_blank[digit_q]) begin
         seg_cat_d = SEG_BLANK;
      end
      if (!wrap && (pwm_cnt_q <= bus.brightness)) seg_an_d[digit_q] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp_q    <= '0;
         ovf_q     <= 1'b0;
         presc_q   <= '0;
         digit_q   <= '0;
         pwm_cnt_q <= '0;
         seg_cat_q <= SEG_BLANK;
         seg_dp_q  <= 1'b1;
         seg_an_q  <= '1;
      end else begin
         disp_q    <= disp_d;
         ovf_q     <= ovf_d;
         presc_q   <= presc_d;
         digit_q   <= digit_d;
         pwm_cnt_q <= pwm_cnt_d;
         seg_cat_q <= seg_cat_d;
         seg_dp_q  <= seg_dp_d;
         seg_an_q  <= seg_an_d;
      end
   end

   assign bus.seg_cat = seg_cat_q;
   assign bus.seg_dp  = seg_dp_q;
   assign bus.seg_an  = seg_an_q;
   assign bus.busy    = conv_busy;
   assign bus.ovf     = ovf_q;

endmodule
